bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It is the reverse path of the team's one-digit BCD adder: that block takes BCD digits and produces a BCD sum, while this block takes a plain binary value (e.g. from SW or a counter) and produces packed BCD digits for the HEX display decoders. A start/busy/done handshake lets a controller request one conversion at a time.

Parameters:
WIDTH, 8, bit width of the binary input.
DIGITS, 3, number of BCD output digits; digit 0 is least significant.

Ports:
CLOCK_50  input  1  system clock; all state changes on its rising edge.
resetn  input  1  asynchronous, active-low reset.
start  input  1  conversion request; sampled only in IDLE.
bin  input  WIDTH  binary operand; captured on the accepted start edge.
busy  output  1  high from the edge after an accepted start until DONE is exited.
done  output  1  one-cycle pulse when the result is valid.
bcd  output  4*DIGITS  packed result; bcd[4i+3:4i] is digit i; holds until the next done.
overflow  output  1  set with done if bin > 10^DIGITS - 1; holds with bcd.

Behaviour:
- Reset (resetn=0, asynchronous, takes effect immediately): state=IDLE, busy=0, done=0, bcd=0, overflow=0, internal shift register and counter=0.
- Reset mid-conversion aborts the conversion. No done pulse is produced, and bcd returns to 0.
- Internal registers:
  - shift register of WIDTH bits;
  - scratch BCD accumulator of 4*DIGITS bits;
  - sticky overflow bit;
  - bit counter of ceil(log2(WIDTH+1)) bits.
- State machine: IDLE, CONVERT, DONE.
- IDLE:
  - If start=1 at the edge: load the shift register with bin, clear the accumulator and sticky overflow, set counter=WIDTH, go to CONVERT.
  - Otherwise remain in IDLE.
- CONVERT, one bit per cycle:
  - First, every accumulator digit >= 5 gets +3 (4-bit add, no carry between digits).
  - Then shift {accumulator, shift register} left by one. The MSB of the shift register enters accumulator bit 0.
  - The bit shifted out of the accumulator MSB ORs into sticky overflow.
  - Decrement the counter. When counter=1 at the edge, go to DONE.
  - CONVERT therefore lasts exactly WIDTH cycles.
- DONE (exactly one cycle):
  - On entry, bcd is loaded from the adjusted/shifted accumulator and overflow from the sticky bit.
  - done=1 for this single cycle, then return to IDLE.
- Latency: with start accepted at edge k, done is high in the cycle following edge k+WIDTH+1. bcd and overflow change at that same edge.
- busy=1 in CONVERT and DONE, and 0 in IDLE.
- start while in CONVERT or DONE is ignored, not queued. A start held high continuously yields back-to-back conversions with one IDLE cycle between them.
- bin changes after the accepted start do not affect the in-flight conversion.
- done, busy and overflow are registered outputs; there is no combinational path from inputs.
- overflow semantics: if overflow=1, bcd holds the low DIGITS digits of the true decimal value, i.e. bin mod 10^DIGITS. Each digit is still a valid BCD value 0–9.
- Every emitted digit is in the range 0–9 for all inputs.

Test Plan:
- Defaults, bin=8'd255, single start pulse → done pulses 10 cycles after the start edge (WIDTH+2 counting the start edge), bcd=12'h255, overflow=0, busy=1 for exactly 9 cycles.
- Defaults, bin=0, then bin=8'd99, then bin=8'd100 → bcd=12'h000, 12'h099 and 12'h100 respectively, with overflow=0 for all three.
- Start pulse with bin=8'd42, then bin changed to 8'd7 and start reasserted during CONVERT → exactly one done, bcd=12'h042. The second start is ignored and produces no extra done.
- resetn pulsed low for 1 cycle midway through converting 8'd200 → busy=0, done=0, bcd=0 immediately. A subsequent start with bin=8'd13 yields bcd=12'h013.
- WIDTH=8, DIGITS=2, bin=8'd200 → done with bcd=8'h00 and overflow=1. Then bin=8'd99 → bcd=8'h99 and overflow=0.
- Exhaustive sweep at defaults, bin 0..255 with start held high → each done yields a bcd equal to the decimal value of bin, consecutive dones are 10 cycles apart, and no digit exceeds 9.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// A controller pulses start with a binary value on bin. One bit is processed
// per clock, and the packed BCD result is presented on bcd with a one-cycle
// done pulse.
//
// The controller FSM walks IDLE -> CONVERT (WIDTH cycles) -> DONE (1 cycle).
// busy, done, bcd and overflow are registered from that state, so they trail
// it by one clock. With start accepted at edge k:
//   - busy rises at edge k+1;
//   - done, bcd and overflow update at edge k+WIDTH+1;
//   - busy falls one edge after that.
// A start held high re-arms on the single IDLE cycle that follows DONE, so
// back-to-back conversions are WIDTH+2 cycles apart.
//
// The accumulator only holds DIGITS digits. Higher-order decimal content
// falls off its MSB and is collected in a sticky overflow bit. The add-3
// correction of a digit depends only on that digit and the carry into it
// from below, so the retained digits are always bin mod 10^DIGITS. Each
// retained digit is a valid 0-9 BCD value.

module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int CW = $clog2(WIDTH + 1);  // bit counter width
  localparam int AW = 4 * DIGITS;         // accumulator width

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [WIDTH-1:0]  shift_reg;
  logic [AW-1:0]     acc;
  logic              sticky;
  logic [CW-1:0]     cnt;

  // Datapath intermediates for one conversion step.
  logic [AW-1:0]     acc_adj;   // accumulator after per-digit +3 correction
  logic [AW+WIDTH:0] shifted;   // {carry_out, acc, shift_reg} after the shift
  logic [AW-1:0]     acc_step;
  logic [WIDTH-1:0]  sr_step;
  logic              carry_out;

  // State register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    // NOTE: every clocked process uses non-blocking (<=) assignments so all
    // registers sample their inputs from the same pre-edge values.
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: accept start only in IDLE, leave CONVERT on the last
  // bit, and spend exactly one cycle in DONE.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves state_next
    // unassigned, which would infer a latch.
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_CONVERT;
        end
      end
      S_CONVERT: begin
        if (cnt == CW'(1)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // One double-dabble step: correct every digit >= 5 by +3 (no carry between
  // digits), then shift {acc, shift_reg} left by one bit.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    shifted   = {acc_adj, shift_reg, 1'b0};
    acc_step  = shifted[AW+WIDTH-1:WIDTH];
    sr_step   = shifted[WIDTH-1:0];
    carry_out = shifted[AW+WIDTH];
  end

  // Conversion datapath. Capture the operand on an accepted start, so later
  // changes on bin do not disturb the conversion in flight. Then consume
  // one bit per CONVERT cycle.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      shift_reg <= '0;
      acc       <= '0;
      sticky    <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            shift_reg <= bin;
            acc       <= '0;
            sticky    <= 1'b0;
            cnt       <= CW'(WIDTH);
          end
        end
        S_CONVERT: begin
          shift_reg <= sr_step;
          acc       <= acc_step;
          sticky    <= sticky | carry_out;
          cnt       <= cnt - CW'(1);
        end
        default: begin
          // DONE: hold the finished accumulator for the output load.
        end
      endcase
    end
  end

  // Registered outputs. busy and done follow the state one clock later.
  // bcd and overflow are loaded once, in the DONE cycle, and then hold until
  // the next result.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      busy <= (state != S_IDLE);
      done <= (state == S_DONE);
      if (state == S_DONE) begin
        bcd      <= acc;
        overflow <= sticky;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq.
// dut_a runs at defaults (WIDTH=8, DIGITS=3). dut_b uses DIGITS=2 to exercise
// overflow. Expected results come from a decimal reference model and are
// queued when a start is driven. They are popped when done is observed.

module tb_bin_to_bcd_seq;

  logic        clk;
  logic        resetn;

  logic        start_a;
  logic [7:0]  bin_a;
  logic        busy_a;
  logic        done_a;
  logic [11:0] bcd_a;
  logic        ovf_a;

  logic        start_b;
  logic [7:0]  bin_b;
  logic        busy_b;
  logic        done_b;
  logic [7:0]  bcd_b;
  logic        ovf_b;

  int          total;
  int          bad;

  // Scoreboard entries: {overflow, bcd[11:0]}.
  logic [12:0] sb_q[$];

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_a (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .start    (start_a),
    .bin      (bin_a),
    .busy     (busy_a),
    .done     (done_a),
    .bcd      (bcd_a),
    .overflow (ovf_a)
  );

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_b (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .start    (start_b),
    .bin      (bin_b),
    .busy     (busy_b),
    .done     (done_b),
    .bcd      (bcd_b),
    .overflow (ovf_b)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Overall time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Decimal reference: low nd digits of v, plus an overflow flag for v >= 10^nd.
  function automatic logic [12:0] model(input int v, input int nd);
    logic [11:0] b;
    int          r;
    b = '0;
    r = v;
    for (int i = 0; i < nd; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return {(r != 0), b};
  endfunction

  // Drives one start pulse on the selected DUT and queues its expected
  // result. Then waits, with a bound, for done. lat counts edges after the
  // accept edge. busy_cyc counts cycles with busy high up to and including
  // the done cycle.
  task automatic convert(input bit sel, input int v,
                         output logic [11:0] got_bcd, output logic got_ovf,
                         output int lat, output int busy_cyc, output bit timed_out);
    @(negedge clk);
    if (sel) begin
      bin_b = 8'(v);
      start_b = 1'b1;
    end else begin
      bin_a = 8'(v);
      start_a = 1'b1;
    end
    sb_q.push_back(model(v, sel ? 2 : 3));
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    lat = 0;
    busy_cyc = (sel ? busy_b : busy_a) ? 1 : 0;
    timed_out = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (sel ? busy_b : busy_a) busy_cyc++;
      if (sel ? done_b : done_a) begin
        timed_out = 1'b0;
        break;
      end
    end
    got_bcd = sel ? {4'h0, bcd_b} : bcd_a;
    got_ovf = sel ? ovf_b : ovf_a;
  endtask

  task automatic test_reset;
    start_a = 1'b0;
    bin_a = '0;
    start_b = 1'b0;
    bin_b = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy_a, done_a, bcd_a, ovf_a} !== 15'h0) begin
      bad++;
      $display("FAIL reset_a: busy=%b done=%b bcd=%h ovf=%b, want all 0", busy_a, done_a, bcd_a, ovf_a);
    end
    total++;
    if ({busy_b, done_b, bcd_b, ovf_b} !== 11'h0) begin
      bad++;
      $display("FAIL reset_b: busy=%b done=%b bcd=%h ovf=%b, want all 0", busy_b, done_b, bcd_b, ovf_b);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy_a, done_a} !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy_a, done_a);
    end
  endtask

  task automatic test_single_255;
    logic [11:0] g;
    logic        o;
    logic [12:0] e;
    int          lat;
    int          bc;
    bit          to;
    convert(1'b0, 255, g, o, lat, bc, to);
    e = sb_q.pop_front();
    total++;
    if (to) begin
      bad++;
      $display("FAIL single_timeout: no done within 30 cycles");
    end
    total++;
    if (g !== e[11:0]) begin
      bad++;
      $display("FAIL single_bcd: got %h want %h", g, e[11:0]);
    end
    total++;
    if (o !== e[12]) begin
      bad++;
      $display("FAIL single_ovf: got %b want %b", o, e[12]);
    end
    total++;
    if (lat != 9) begin
      bad++;
      $display("FAIL single_latency: done %0d edges after start edge, want 9", lat);
    end
    total++;
    if (bc != 9) begin
      bad++;
      $display("FAIL single_busy_len: busy high %0d cycles, want 9", bc);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy_a, done_a} !== 2'b00) begin
      bad++;
      $display("FAIL single_after: busy=%b done=%b, want 0 0", busy_a, done_a);
    end
    total++;
    if (bcd_a !== 12'h255) begin
      bad++;
      $display("FAIL single_hold: bcd=%h want 255", bcd_a);
    end
  endtask

  task automatic test_patterns;
    int          vals[3] = '{0, 99, 100};
    logic [11:0] g;
    logic        o;
    logic [12:0] e;
    int          lat;
    int          bc;
    bit          to;
    foreach (vals[i]) begin
      convert(1'b0, vals[i], g, o, lat, bc, to);
      e = sb_q.pop_front();
      total++;
      if (to || g !== e[11:0] || o !== e[12]) begin
        bad++;
        $display("FAIL pattern_%0d: got bcd=%h ovf=%b timeout=%b want bcd=%h ovf=%b",
                 vals[i], g, o, to, e[11:0], e[12]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int          dones;
    logic [12:0] e;
    @(negedge clk);
    bin_a = 8'd42;
    start_a = 1'b1;
    sb_q.push_back(model(42, 3));
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    dones = 0;
    repeat (2) @(negedge clk);
    bin_a = 8'd7;
    start_a = 1'b1;
    for (int c = 0; c < 28; c++) begin
      if (c == 3) start_a = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (done_a) begin
        dones++;
        e = sb_q.pop_front();
        total++;
        if (bcd_a !== e[11:0] || ovf_a !== e[12]) begin
          bad++;
          $display("FAIL ignore_bcd: got %h ovf=%b want %h ovf=%b", bcd_a, ovf_a, e[11:0], e[12]);
        end
      end
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL ignore_done_count: got %0d dones want 1", dones);
    end
  endtask

  task automatic test_reset_mid;
    logic [11:0] g;
    logic        o;
    logic [12:0] e;
    int          lat;
    int          bc;
    bit          to;
    int          dones;
    @(negedge clk);
    bin_a = 8'd200;
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (busy_a !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pre_busy: got %b want 1", busy_a);
    end
    #2;
    resetn = 1'b0;
    #1;
    total++;
    if ({busy_a, done_a, bcd_a} !== 14'h0) begin
      bad++;
      $display("FAIL midreset_clear: busy=%b done=%b bcd=%h want 0 0 000", busy_a, done_a, bcd_a);
    end
    @(negedge clk);
    resetn = 1'b1;
    dones = 0;
    repeat (14) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    total++;
    if (dones != 0 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL midreset_abort: dones=%0d busy=%b want 0 0", dones, busy_a);
    end
    convert(1'b0, 13, g, o, lat, bc, to);
    e = sb_q.pop_front();
    total++;
    if (to || g !== e[11:0] || o !== e[12]) begin
      bad++;
      $display("FAIL midreset_next: got bcd=%h ovf=%b timeout=%b want %h %b", g, o, to, e[11:0], e[12]);
    end
  endtask

  task automatic test_digits2;
    int          vals[2] = '{200, 99};
    logic [11:0] g;
    logic        o;
    logic [12:0] e;
    int          lat;
    int          bc;
    bit          to;
    foreach (vals[i]) begin
      convert(1'b1, vals[i], g, o, lat, bc, to);
      e = sb_q.pop_front();
      total++;
      if (to || g !== e[11:0]) begin
        bad++;
        $display("FAIL d2_bcd_%0d: got %h timeout=%b want %h", vals[i], g, to, e[11:0]);
      end
      total++;
      if (o !== e[12]) begin
        bad++;
        $display("FAIL d2_ovf_%0d: got %b want %b", vals[i], o, e[12]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int          edges;
    int          last_edge;
    bit          found;
    logic [12:0] e;
    edges = 0;
    last_edge = 0;
    @(negedge clk);
    bin_a = 8'd0;
    start_a = 1'b1;
    sb_q.push_back(model(0, 3));
    for (int v = 0; v < 256; v++) begin
      found = 1'b0;
      for (int c = 0; c < 30; c++) begin
        @(posedge clk);
        edges++;
        @(negedge clk);
        if (done_a) begin
          found = 1'b1;
          break;
        end
      end
      total++;
      if (!found) begin
        bad++;
        $display("FAIL sweep_timeout: no done for bin=%0d", v);
        start_a = 1'b0;
        break;
      end
      e = sb_q.pop_front();
      total++;
      if (bcd_a !== e[11:0] || ovf_a !== e[12]) begin
        bad++;
        $display("FAIL sweep_bcd_%0d: got %h ovf=%b want %h ovf=%b", v, bcd_a, ovf_a, e[11:0], e[12]);
      end
      for (int d = 0; d < 3; d++) begin
        total++;
        if (bcd_a[4*d +: 4] > 4'd9) begin
          bad++;
          $display("FAIL sweep_digit_%0d_%0d: digit=%h exceeds 9", v, d, bcd_a[4*d +: 4]);
        end
      end
      if (v > 0) begin
        total++;
        if (edges - last_edge != 10) begin
          bad++;
          $display("FAIL sweep_gap_%0d: got %0d cycles want 10", v, edges - last_edge);
        end
      end
      last_edge = edges;
      if (v < 255) begin
        bin_a = 8'(v + 1);
        sb_q.push_back(model(v + 1, 3));
      end else begin
        start_a = 1'b0;
      end
    end
    start_a = 1'b0;
    repeat (12) @(negedge clk);
    total++;
    if (busy_a !== 1'b0 || sb_q.size() != 0) begin
      bad++;
      $display("FAIL sweep_end: busy=%b pending=%0d want 0 0", busy_a, sb_q.size());
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset;
    test_single_255;
    test_patterns;
    test_ignore_start;
    test_reset_mid;
    test_digits2;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
